// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3, memory port and FSM state encodings for the load/store master.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WE_NONE = 2'd0;
    localparam logic [1:0] WE_SB   = 2'd1;
    localparam logic [1:0] WE_SH   = 2'd2;
    localparam logic [1:0] WE_SW   = 2'd3;

    localparam logic [2:0] RE_NONE = 3'd0;
    localparam logic [2:0] RE_LB   = 3'd1;
    localparam logic [2:0] RE_LH   = 3'd2;
    localparam logic [2:0] RE_LW   = 3'd3;
    localparam logic [2:0] RE_LBU  = 3'd4;
    localparam logic [2:0] RE_LHU  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/lsu_mem_master_decode.sv
// lsu_decode: maps a load/store request to memory port codes and error flags.
// MISALIGN_TRAP_EN turns unaligned halfword/word accesses into errors.
module lsu_decode
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64
) (
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  we,
    output logic [2:0]  re,
    output logic        illegal,
    output logic        misaligned,
    output logic        out_of_range
);
    logic [2:0] size;

    always_comb begin
        illegal = is_store ? !(funct3 inside {F3_B, F3_H, F3_W})
                           : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        size = funct3[1:0] == 2'b00 ? 3'd1 : funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
        we = (!is_store || illegal) ? WE_NONE :
             funct3 == F3_B ? WE_SB : funct3 == F3_H ? WE_SH : WE_SW;
        re = (is_store || illegal) ? RE_NONE :
             funct3 == F3_B  ? RE_LB  : funct3 == F3_H  ? RE_LH :
             funct3 == F3_W  ? RE_LW  : funct3 == F3_BU ? RE_LBU : RE_LHU;
        // 33-bit sum so an address that wraps past 2^32 is caught as out of range
        out_of_range = ({1'b0, addr} + 33'(size)) > 33'(MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
        misaligned = (size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator driving a byte-addressed data memory.
// Optional MISALIGN_TRAP_EN (handled in lsu_decode) reports unaligned accesses as errors.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_we,
    output logic [2:0]  mem_re,
    input  logic [31:0] mem_rdata
);
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    state_t        state;
    logic          op_store;
    logic [CW-1:0] cnt;
    logic [1:0]    dec_we;
    logic [2:0]    dec_re;
    logic          dec_illegal, dec_misaligned, dec_oor;

    lsu_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
        .is_store    (req_is_store),
        .funct3      (req_funct3),
        .addr        (req_addr),
        .we          (dec_we),
        .re          (dec_re),
        .illegal     (dec_illegal),
        .misaligned  (dec_misaligned),
        .out_of_range(dec_oor)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_we      <= WE_NONE;
            mem_re      <= RE_NONE;
            op_store    <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    op_store  <= req_is_store;
                    cnt       <= CW'(RD_LAT - 1);
                    if (dec_illegal || dec_oor || dec_misaligned) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state       <= S_ACCESS;
                        mem_address <= req_addr;
                        mem_wdata   <= req_wdata;
                        mem_we      <= dec_we;
                        mem_re      <= dec_re;
                    end
                end
                // stores finish after one cycle; loads count down RD_LAT edges
                S_ACCESS, S_WAIT: if (op_store || cnt == '0) begin
                    mem_we    <= WE_NONE;
                    mem_re    <= RE_NONE;
                    rsp_rdata <= op_store ? '0 : mem_rdata;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end else begin
                    cnt   <= cnt - 1'b1;
                    state <= S_WAIT;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
